rename_map_ckpt: RTL and testbench

- Parametrised register-alias table for the rename stage; one instruction renamed per cycle.
- Per logical register it holds a physical tag and a ready bit. Each rename returns ready-tagged source mappings, installs the newly allocated destination tag, and reports the superseded tag for freeing.
- Writeback broadcasts set ready bits.
- A circular checkpoint buffer snapshots the map at branches, so a mispredict restores the map in one cycle.

---
 rtl/rename_map_ckpt_if.sv | 47 ++++
 rtl/rename_map_ckpt.sv | 125 ++++++++++++
 tb/tb_rename_map_ckpt.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_map_ckpt_if.sv
// Rename-stage bus for rename_map_ckpt: rename request/response, writeback
// broadcast, branch resolve/mispredict and checkpoint occupancy.
interface rename_map_ckpt_if #(
  parameter int LREG_BITS = 4,
  parameter int PREG_BITS = 6,
  parameter int CKPT_BITS = 2
);
  // Handshake: a rename is consumed on a cycle where ren_vld && ren_rdy; every
  // ren_* response is combinational in that same cycle and meaningful only then.
  logic                 ren_vld;
  logic                 ren_rdy;
  logic                 ren_src1_vld;
  logic                 ren_src2_vld;
  logic [LREG_BITS-1:0] ren_src1;
  logic [LREG_BITS-1:0] ren_src2;
  logic                 ren_dst_vld;
  logic [LREG_BITS-1:0] ren_dst;
  logic [PREG_BITS-1:0] ren_pdst;
  logic                 ren_ckpt;
  logic [PREG_BITS:0]   ren_psrc1;
  logic [PREG_BITS:0]   ren_psrc2;
  logic                 ren_fre_vld;
  logic [PREG_BITS-1:0] ren_fre_preg;
  logic [CKPT_BITS-1:0] ren_ckpt_id;
  logic                 wb_vld;
  logic [PREG_BITS-1:0] wb_preg;
  logic                 rslv_ok;
  logic                 misp_vld;
  logic [CKPT_BITS-1:0] misp_id;
  logic [CKPT_BITS:0]   ckpt_cnt;

  modport master (
    output ren_vld, ren_src1_vld, ren_src2_vld, ren_src1, ren_src2,
           ren_dst_vld, ren_dst, ren_pdst, ren_ckpt, wb_vld, wb_preg,
           rslv_ok, misp_vld, misp_id,
    input  ren_rdy, ren_psrc1, ren_psrc2, ren_fre_vld, ren_fre_preg,
           ren_ckpt_id, ckpt_cnt
  );

  modport slave (
    input  ren_vld, ren_src1_vld, ren_src2_vld, ren_src1, ren_src2,
           ren_dst_vld, ren_dst, ren_pdst, ren_ckpt, wb_vld, wb_preg,
           rslv_ok, misp_vld, misp_id,
    output ren_rdy, ren_psrc1, ren_psrc2, ren_fre_vld, ren_fre_preg,
           ren_ckpt_id, ckpt_cnt
  );
endinterface

// File: rtl/rename_map_ckpt.sv
// Register-alias table with ready bits and a circular checkpoint buffer that
// restores the whole map in one cycle on a branch mispredict.
module rename_map_ckpt #(
  parameter int NUM_LREG   = 16,
  parameter int LREG_BITS  = 4,
  parameter int PREG_BITS  = 6,
  parameter int CKPT_DEPTH = 4,
  parameter int CKPT_BITS  = 2
) (
  input logic              clk,
  input logic              rst_n,
  rename_map_ckpt_if.slave rif
);

  logic [PREG_BITS-1:0]  map_tag [NUM_LREG];
  logic [NUM_LREG-1:0]   map_rdy;
  logic [PREG_BITS-1:0]  ck_tag  [CKPT_DEPTH][NUM_LREG];
  logic [NUM_LREG-1:0]   ck_rdy  [CKPT_DEPTH];
  logic [CKPT_DEPTH-1:0] ck_vld, ck_vld_n;
  logic [CKPT_BITS-1:0]  head, tail, head_n, off;
  logic [CKPT_BITS:0]    cnt_q, cnt_n, misp_cnt;

  logic                  fire, alloc, rel, misp_eff;
  logic [LREG_BITS-1:0]  src1, src2, dst;
  logic [PREG_BITS-1:0]  nxt_tag [NUM_LREG];
  logic [NUM_LREG-1:0]   nxt_rdy, rst_rdy;
  logic [NUM_LREG-1:0]   ck_rdy_wb [CKPT_DEPTH];

  assign src1 = rif.ren_src1;
  assign src2 = rif.ren_src2;
  assign dst  = rif.ren_dst;

  assign rif.ren_rdy      = !rif.misp_vld &&
                            !(rif.ren_ckpt && cnt_q == (CKPT_BITS+1)'(CKPT_DEPTH));
  assign fire             = rif.ren_vld && rif.ren_rdy;
  assign rif.ren_fre_vld  = fire && rif.ren_dst_vld;
  assign rif.ren_fre_preg = map_tag[dst];
  assign rif.ren_ckpt_id  = tail;
  assign rif.ckpt_cnt     = cnt_q;

  // Source lookups see the map before this cycle's destination write.
  always_comb begin
    rif.ren_psrc1 = {1'b1, {PREG_BITS{1'b0}}};
    rif.ren_psrc2 = {1'b1, {PREG_BITS{1'b0}}};
    if (rif.ren_vld && rif.ren_src1_vld)
      rif.ren_psrc1 = {map_rdy[src1] | (rif.wb_vld && rif.wb_preg == map_tag[src1]),
                       map_tag[src1]};
    if (rif.ren_vld && rif.ren_src2_vld)
      rif.ren_psrc2 = {map_rdy[src2] | (rif.wb_vld && rif.wb_preg == map_tag[src2]),
                       map_tag[src2]};
  end

  always_comb begin
    alloc    = fire && rif.ren_ckpt;
    rel      = rif.rslv_ok && (cnt_q != '0);
    head_n   = head + CKPT_BITS'(rel);
    // A resolve releasing the very slot being restored wins over the mispredict.
    misp_eff = rif.misp_vld && ck_vld[rif.misp_id] && !(rel && head == rif.misp_id);
    misp_cnt = {1'b0, rif.misp_id - head_n};
    cnt_n    = cnt_q + (CKPT_BITS+1)'(alloc) - (CKPT_BITS+1)'(rel);

    nxt_tag = map_tag;
    nxt_rdy = map_rdy;
    for (int i = 0; i < NUM_LREG; i++)
      if (rif.wb_vld && map_tag[i] == rif.wb_preg) nxt_rdy[i] = 1'b1;
    if (fire && rif.ren_dst_vld) begin
      nxt_tag[dst] = rif.ren_pdst;
      nxt_rdy[dst] = 1'b0;
    end

    for (int j = 0; j < CKPT_DEPTH; j++) begin
      ck_rdy_wb[j] = ck_rdy[j];
      for (int i = 0; i < NUM_LREG; i++)
        if (rif.wb_vld && ck_tag[j][i] == rif.wb_preg) ck_rdy_wb[j][i] = 1'b1;
    end
    rst_rdy = ck_rdy_wb[rif.misp_id];

    ck_vld_n = ck_vld;
    off      = '0;
    if (rel)   ck_vld_n[head] = 1'b0;
    if (alloc) ck_vld_n[tail] = 1'b1;
    // Keep only the slots older than the restored one, counted from the new head.
    if (misp_eff) begin
      for (int j = 0; j < CKPT_DEPTH; j++) begin
        off = CKPT_BITS'(j) - head_n;
        if ({1'b0, off} >= misp_cnt) ck_vld_n[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LREG; i++) map_tag[i] <= PREG_BITS'(i);
      map_rdy <= '1;
      for (int j = 0; j < CKPT_DEPTH; j++) begin
        ck_rdy[j] <= '0;
        for (int i = 0; i < NUM_LREG; i++) ck_tag[j][i] <= '0;
      end
      ck_vld <= '0;
      head   <= '0;
      tail   <= '0;
      cnt_q  <= '0;
    end else begin
      ck_vld <= ck_vld_n;
      head   <= head_n;
      for (int j = 0; j < CKPT_DEPTH; j++) ck_rdy[j] <= ck_rdy_wb[j];
      if (alloc) begin
        for (int i = 0; i < NUM_LREG; i++) ck_tag[tail][i] <= nxt_tag[i];
        ck_rdy[tail] <= nxt_rdy;
        tail         <= tail + 1'b1;
      end
      if (misp_eff) begin
        for (int i = 0; i < NUM_LREG; i++) map_tag[i] <= ck_tag[rif.misp_id][i];
        map_rdy <= rst_rdy;
        tail    <= rif.misp_id;
        cnt_q   <= misp_cnt;
      end else begin
        for (int i = 0; i < NUM_LREG; i++) map_tag[i] <= nxt_tag[i];
        map_rdy <= nxt_rdy;
        cnt_q   <= cnt_n;
      end
    end
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Bench for rename_map_ckpt: directed scenarios then random traffic, checked
// against a map-plus-snapshot-queue model through an expected-response queue.
module tb_rename_map_ckpt;
  localparam int NL = 16;
  localparam int LB = 4;
  localparam int PB = 6;
  localparam int CD = 4;
  localparam int CB = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rename_map_ckpt_if #(.LREG_BITS(LB), .PREG_BITS(PB), .CKPT_BITS(CB)) rif();

  rename_map_ckpt #(
    .NUM_LREG(NL), .LREG_BITS(LB), .PREG_BITS(PB), .CKPT_DEPTH(CD), .CKPT_BITS(CB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rif(rif)
  );

  typedef struct packed {
    logic          rdy;
    logic          fre_vld;
    logic [PB-1:0] fre_preg;
    logic [PB:0]   psrc1;
    logic [PB:0]   psrc2;
    logic [CB-1:0] id;
    logic [CB:0]   cnt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  typedef struct packed {
    logic [CB-1:0]    id;
    logic [NL*PB-1:0] tags;
    logic [NL-1:0]    rdy;
  } snap_t;

  // ---------------- reference model ----------------
  logic [PB-1:0] m_tag [NL];
  logic [NL-1:0] m_rdy;
  snap_t         ck_q[$];     // outstanding branches, oldest first
  logic [CB-1:0] m_next_id;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_tag[i] = PB'(i);
    m_rdy = '1;
    ck_q.delete();
    m_next_id = '0;
  endtask

  function automatic logic [PB:0] src_val(input logic present, input logic [LB-1:0] s,
                                          input logic wbv, input logic [PB-1:0] wbp);
    if (!present) return {1'b1, {PB{1'b0}}};
    return {m_rdy[s] | (wbv && wbp == m_tag[s]), m_tag[s]};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic vld, input logic s1v, input logic [LB-1:0] s1,
                      input logic s2v, input logic [LB-1:0] s2,
                      input logic dv, input logic [LB-1:0] d, input logic [PB-1:0] pd,
                      input logic ck, input logic wbv, input logic [PB-1:0] wbp,
                      input logic rs, input logic mv, input logic [CB-1:0] mid);
    exp_t  e;
    snap_t sn;
    logic  fire;
    int    k;
    rif.ren_vld = vld; rif.ren_src1_vld = s1v; rif.ren_src1 = s1;
    rif.ren_src2_vld = s2v; rif.ren_src2 = s2; rif.ren_dst_vld = dv;
    rif.ren_dst = d; rif.ren_pdst = pd; rif.ren_ckpt = ck;
    rif.wb_vld = wbv; rif.wb_preg = wbp; rif.rslv_ok = rs;
    rif.misp_vld = mv; rif.misp_id = mid;

    e.rdy      = !mv && !(ck && ck_q.size() == CD);
    fire       = vld && e.rdy;
    e.psrc1    = src_val(vld && s1v, s1, wbv, wbp);
    e.psrc2    = src_val(vld && s2v, s2, wbv, wbp);
    e.fre_vld  = fire && dv;
    e.fre_preg = m_tag[d];
    e.id       = m_next_id;
    e.cnt      = (CB+1)'(ck_q.size());
    exp_q.push_back(EW'(e));

    // advance the model: writeback, destination, resolve, branch, mispredict
    if (wbv) begin
      for (int i = 0; i < NL; i++) if (m_tag[i] == wbp) m_rdy[i] = 1'b1;
      for (int q = 0; q < ck_q.size(); q++)
        for (int i = 0; i < NL; i++)
          if (ck_q[q].tags[i*PB +: PB] == wbp) ck_q[q].rdy[i] = 1'b1;
    end
    if (fire && dv) begin
      m_tag[d] = pd;
      m_rdy[d] = 1'b0;
    end
    if (rs && ck_q.size() > 0) void'(ck_q.pop_front());
    if (fire && ck) begin
      sn.id = m_next_id;
      for (int i = 0; i < NL; i++) sn.tags[i*PB +: PB] = m_tag[i];
      sn.rdy = m_rdy;
      ck_q.push_back(sn);
      m_next_id = m_next_id + 1'b1;
    end
    if (mv) begin
      k = -1;
      for (int q = 0; q < ck_q.size(); q++) if (ck_q[q].id == mid) k = q;
      if (k >= 0) begin
        for (int i = 0; i < NL; i++) m_tag[i] = ck_q[k].tags[i*PB +: PB];
        m_rdy = ck_q[k].rdy;
        m_next_id = mid;
        while (ck_q.size() > k) void'(ck_q.pop_back());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_step();
    logic vld, s1v, s2v, dv, ck, wbv, rs, mv;
    logic [LB-1:0] s1, s2, d;
    logic [PB-1:0] pd, wbp;
    logic [CB-1:0] mid;
    vld = ($urandom_range(0, 3) != 0);
    s1v = $urandom_range(0, 1); s2v = $urandom_range(0, 1); dv = ($urandom_range(0, 3) != 0);
    s1 = LB'($urandom); s2 = LB'($urandom); d = LB'($urandom);
    pd = PB'($urandom);
    ck = ($urandom_range(0, 2) == 0);
    wbv = $urandom_range(0, 1);
    wbp = ($urandom_range(0, 2) == 0) ? PB'($urandom) : m_tag[$urandom_range(0, NL-1)];
    if (wbp == pd) pd = pd ^ 6'd1;
    rs = ($urandom_range(0, 3) == 0);
    mv = ($urandom_range(0, 11) == 0);
    mid = CB'($urandom);
    step(vld, s1v, s1, s2v, s2, dv, d, pd, ck, wbv, wbp, rs, mv, mid);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, got, exp);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_t'(exp_q.pop_front());
      chk("ren_rdy",     8'(rif.ren_rdy),     8'(me.rdy));
      chk("ren_psrc1",   8'(rif.ren_psrc1),   8'(me.psrc1));
      chk("ren_psrc2",   8'(rif.ren_psrc2),   8'(me.psrc2));
      chk("ren_fre_vld", 8'(rif.ren_fre_vld), 8'(me.fre_vld));
      if (me.fre_vld) chk("ren_fre_preg", 8'(rif.ren_fre_preg), 8'(me.fre_preg));
      chk("ren_ckpt_id", 8'(rif.ren_ckpt_id), 8'(me.id));
      chk("ckpt_cnt",    8'(rif.ckpt_cnt),    8'(me.cnt));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rif.ren_vld = 0; rif.ren_src1_vld = 0; rif.ren_src2_vld = 0; rif.ren_src1 = 0;
    rif.ren_src2 = 0; rif.ren_dst_vld = 0; rif.ren_dst = 0; rif.ren_pdst = 0;
    rif.ren_ckpt = 0; rif.wb_vld = 0; rif.wb_preg = 0; rif.rslv_ok = 0;
    rif.misp_vld = 0; rif.misp_id = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    idle();                                                   // reset state
    step(1, 1, 3, 1, 5, 1, 3, 6'h20, 0, 0, 0, 0, 0, 0);       // 0x43 / 0x45, free 0x03
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);           // sees 0x20
    step(1, 0, 0, 0, 0, 1, 7, 6'h07, 0, 0, 0, 0, 0, 0);       // map[7] = 0x07 not ready
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 6'h07, 0, 0, 0);       // bypass -> 0x47
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);           // stays ready

    repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // ids 0..3
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);           // full: stalled
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);           // resolve
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);           // wraps to id 0
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);           // branch id 1
    step(1, 0, 0, 0, 0, 1, 2, 6'h30, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 1, 5, 6'h31, 0, 0, 0, 0, 1, 1);       // mispredict, rename stalls
    step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);           // restored map[2]

    step(1, 0, 0, 0, 0, 1, 4, 6'h11, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);           // snapshot with map[4] busy
    step(1, 0, 0, 0, 0, 1, 4, 6'h12, 0, 1, 6'h11, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);           // restore -> 0x51
    step(1, 1, 4, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 6, 1, 9, 1, 6, 6'h22, 1, 0, 0, 0, 0, 0);       // ren_vld=0
    step(1, 0, 6, 0, 9, 0, 6, 6'h22, 0, 0, 0, 0, 0, 0);       // absent sources
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);           // invalid slot: ignored
    step(1, 1, 4, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    repeat (1500) rand_step();

    rst_n = 1'b0;                                             // reset mid-operation
    model_reset();
    #3 rst_n = 1'b1;
    idle();
    repeat (400) rand_step();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
